// File: rtl/mux_41_rr_sched.sv
// Round-robin scheduler and registered output stage for a 4-lane
// valid-qualified mux. Arbitrates among four requesters and captures the
// winning word into data_out. It also returns a one-cycle ack to the winner
// and honours downstream backpressure through ready_out.
module mux_41_rr_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic             valid_3,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [1:0]       sel,
  output logic             ack_0,
  output logic             ack_1,
  output logic             ack_2,
  output logic             ack_3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       last_q,  last_d;
  logic [1:0]       cnt_q,   cnt_d;

  logic [3:0]       vld;
  logic [WIDTH-1:0] lane_data [4];
  logic             load;
  logic             keep;
  logic             found;
  logic [1:0]       win_rr;
  logic [1:0]       win_idx;
  logic             has_win;
  logic [3:0]       ack_vec;

  assign vld          = {valid_3, valid_2, valid_1, valid_0};
  assign lane_data[0] = data_0;
  assign lane_data[1] = data_1;
  assign lane_data[2] = data_2;
  assign lane_data[3] = data_3;

  assign valid_out = (state_q != IDLE);
  assign data_out  = data_q;
  assign sel       = sel_q;
  assign load      = ~valid_out | ready_out;

  // The owner keeps the lane only while it is actively sending; after an idle
  // gap a returning lane competes through the rotation like everybody else.
  assign keep = valid_out && vld[sel_q] && ((32'(cnt_q) + 32'd1) < BURST);

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    found  = 1'b0;
    win_rr = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && vld[idx]) begin
        found  = 1'b1;
        win_rr = idx;
      end
    end
  end

  // Winner resolution and one-hot ack; no path from the data lanes.
  always_comb begin
    win_idx = keep ? sel_q : win_rr;
    has_win = load && (keep || found);
    ack_vec = '0;
    if (has_win && !reset) begin
      ack_vec = 4'b0001 << win_idx;
    end
  end

  assign ack_0 = ack_vec[0];
  assign ack_1 = ack_vec[1];
  assign ack_2 = ack_vec[2];
  assign ack_3 = ack_vec[3];

  // Next-state logic for the FSM, capture registers and burst counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (has_win) state_d = SEND;
      end
      SEND, STALL: begin
        if (!load)        state_d = STALL;
        else if (has_win) state_d = SEND;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (has_win) begin
      data_d = lane_data[win_idx];
      sel_d  = win_idx;
      last_d = win_idx;
      cnt_d  = keep ? cnt_q + 2'd1 : '0;
    end else if (load) begin
      cnt_d  = '0;
    end
  end

  // State registers with asynchronous reset; last=3 gives lane 0 first turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_41_rr_sched.sv
// Bench for mux_41_rr_sched: two instances (BURST=1 and BURST=3) share the
// same stimulus. Expected outputs are pushed to a scoreboard when inputs are
// driven and popped after the capturing edge.
module tb_mux_41_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic       rdy;

  logic [3:0] o1_data, o3_data;
  logic       o1_v, o3_v;
  logic [1:0] o1_sel, o3_sel;
  logic       a1_0, a1_1, a1_2, a1_3;
  logic       a3_0, a3_1, a3_2, a3_3;

  always #5 clk = ~clk;

  mux_41_rr_sched #(.WIDTH(4), .BURST(1)) u_b1 (
    .clk(clk), .reset(reset),
    .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3),
    .valid_0(v0), .valid_1(v1), .valid_2(v2), .valid_3(v3),
    .ready_out(rdy), .data_out(o1_data), .valid_out(o1_v), .sel(o1_sel),
    .ack_0(a1_0), .ack_1(a1_1), .ack_2(a1_2), .ack_3(a1_3)
  );

  mux_41_rr_sched #(.WIDTH(4), .BURST(3)) u_b3 (
    .clk(clk), .reset(reset),
    .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3),
    .valid_0(v0), .valid_1(v1), .valid_2(v2), .valid_3(v3),
    .ready_out(rdy), .data_out(o3_data), .valid_out(o3_v), .sel(o3_sel),
    .ack_0(a3_0), .ack_1(a3_1), .ack_2(a3_2), .ack_3(a3_3)
  );

  typedef struct {
    logic [6:0] e1;  // {valid_out, sel, data_out} for BURST=1
    logic [6:0] e3;  // same for BURST=3
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] ld [4];

  // Reference state per instance: index 0 is BURST=1, index 1 is BURST=3.
  int         m_last [2];
  int         m_sel  [2];
  int         m_cnt  [2];
  logic       m_v    [2];
  logic [3:0] m_data [2];
  int         m_burst [2] = '{1, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_last[m] = 3; m_sel[m] = 0; m_cnt[m] = 0; m_v[m] = 1'b0; m_data[m] = 4'h0;
    end
  endfunction

  // Advance one instance's reference by one edge; returns the ack expected now.
  function automatic logic [3:0] model_step(input int m, input logic [3:0] v, input logic r);
    logic ld_en;
    int   win;
    bit   stay;
    ld_en = !m_v[m] || r;
    win   = -1;
    stay  = 1'b0;
    if (ld_en) begin
      if (m_v[m] && v[m_sel[m]] && (m_cnt[m] + 1 < m_burst[m])) begin
        win  = m_sel[m];
        stay = 1'b1;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && v[(m_last[m] + k) % 4]) win = (m_last[m] + k) % 4;
        end
      end
    end
    if (!ld_en) return 4'b0000;
    if (win < 0) begin
      m_v[m]   = 1'b0;
      m_cnt[m] = 0;
      return 4'b0000;
    end
    m_data[m] = ld[win];
    m_sel[m]  = win;
    m_last[m] = win;
    m_v[m]    = 1'b1;
    m_cnt[m]  = stay ? m_cnt[m] + 1 : 0;
    return 4'b0001 << win;
  endfunction

  // One clock: drive inputs, check acks, push expectation, pop after the edge.
  task automatic drive_cycle(input logic [3:0] v, input logic r);
    exp_t       e;
    exp_t       got_e;
    logic [3:0] x1, x3;
    {v3, v2, v1, v0} = v;
    rdy = r;
    d0 = ld[0]; d1 = ld[1]; d2 = ld[2]; d3 = ld[3];
    #1;
    x1 = model_step(0, v, r);
    x3 = model_step(1, v, r);
    check_eq("ack_b1", 32'({a1_3, a1_2, a1_1, a1_0}), 32'(x1));
    check_eq("ack_b3", 32'({a3_3, a3_2, a3_1, a3_0}), 32'(x3));
    e.e1 = {m_v[0], 2'(m_sel[0]), m_data[0]};
    e.e3 = {m_v[1], 2'(m_sel[1]), m_data[1]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      check_eq("out_b1", 32'({o1_v, o1_sel, o1_data}), 32'(got_e.e1));
      check_eq("out_b3", 32'({o3_v, o3_sel, o3_data}), 32'(got_e.e3));
    end
  endtask

  // Assert reset between edges, check the immediate drop, release mid-cycle.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_b1", 32'({o1_v, o1_sel, o1_data, a1_3, a1_2, a1_1, a1_0}), 32'd0);
    check_eq("rst_b3", 32'({o3_v, o3_sel, o3_data, a3_3, a3_2, a3_1, a3_0}), 32'd0);
    model_reset();
    sb.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int         bseq [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    logic [1:0] s_hold;
    logic [3:0] dd_hold;

    reset = 1'b1;
    rdy = 1'b1;
    {v3, v2, v1, v0} = 4'b0000;
    ld[0] = 4'h0; ld[1] = 4'hA; ld[2] = 4'h5; ld[3] = 4'hF;
    d0 = ld[0]; d1 = ld[1]; d2 = ld[2]; d3 = ld[3];
    @(posedge clk);
    #1;
    do_reset();

    // Round robin (BURST=1) and burst (BURST=3) with every lane valid.
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'hF, 1'b1);
      check_eq("rr_sel_b1", 32'(o1_sel), 32'(i % 4));
      check_eq("burst_sel_b3", 32'(o3_sel), 32'(bseq[i]));
      if (i < 4) check_eq("rr_data_b1", 32'(o1_data), 32'(ld[i]));
    end

    // Reset in the middle of a transfer; first word afterwards is lane 0.
    do_reset();
    drive_cycle(4'hF, 1'b1);
    check_eq("first_data", 32'(o1_data), 32'h0);
    check_eq("first_sel", 32'(o1_sel), 32'd0);

    // Lane 1 drops after one beat: BURST=3 instance moves on to lane 2.
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(4'hF, 1'b1);
    check_eq("b3_lane1", 32'(o3_sel), 32'd1);
    drive_cycle(4'b1101, 1'b1);
    check_eq("b3_drop", 32'(o3_sel), 32'd2);
    for (int i = 0; i < 3; i++) drive_cycle(4'hF, 1'b1);
    check_eq("b3_after_drop", 32'(o3_sel), 32'd3);

    // Backpressure for three cycles.
    drive_cycle(4'hF, 1'b1);
    s_hold  = o1_sel;
    dd_hold = o1_data;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'hF, 1'b0);
      check_eq("stall_sel", 32'(o1_sel), 32'(s_hold));
      check_eq("stall_data", 32'(o1_data), 32'(dd_hold));
    end
    drive_cycle(4'hF, 1'b1);
    check_eq("resume_sel", 32'(o1_sel), 32'(s_hold + 2'd1));

    // Sparse: only lane 2, toggling every other cycle, with changing data.
    for (int i = 0; i < 6; i++) begin
      ld[2] = 4'(i + 1);
      drive_cycle((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1);
      check_eq("sparse_v", 32'(o1_v), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("sparse_sel", 32'(o1_sel), 32'd2);
    end
    ld[2] = 4'h5;

    // Wrap: only lanes 3 and 0.
    for (int i = 0; i < 6; i++) begin
      drive_cycle(4'b1001, 1'b1);
      check_eq("wrap_sel", 32'(o1_sel), (i % 2 == 0) ? 32'd3 : 32'd0);
    end

    // Random traffic including ready low while idle.
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 4; k++) ld[k] = 4'($urandom_range(0, 15));
      drive_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
